// File: rtl/qspi_slave_sync.sv
// qspi_slave_sync: oversampled QSPI slave bridging quad write/read frames onto a single-port RAM bus
module qspi_slave_sync #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 24,
  parameter int DUMMY_CYCLES = 4,
  parameter int RD_LATENCY   = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_qspi_sck,
  input  logic                  I_qspi_cs,
  input  logic [3:0]            i_qspi_io,
  output logic [3:0]            o_qspi_io,
  output logic                  o_qspi_oe,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_we,
  output logic                  o_re,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_busy,
  output logic                  o_err
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_WDATA  = 3'd4;
  localparam logic [2:0] S_RDATA  = 3'd5;
  localparam logic [2:0] S_IGNORE = 3'd6;
  localparam logic [4:0] C_LAST  = 5'd7;
  localparam logic [4:0] A_LAST  = 5'(ADDR_WIDTH / 4 - 1);
  localparam logic [4:0] D_LAST  = 5'(DATA_WIDTH / 4 - 1);
  localparam logic [4:0] DM_LAST = 5'(DUMMY_CYCLES - 1);
  logic [5:0] sync_q [SYNC_STAGES];
  logic cs_s, sck_s;
  logic [3:0] io_s;
  logic sck_d_q, cs_d_q;
  logic rise, fall, cs_fall;
  logic [2:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] op_q, op_d;
  logic wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] ash_q, ash_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] stage_q, stage_d;
  logic [RD_LATENCY-1:0] re_pipe_q, re_pipe_d;
  logic we_q, we_d;
  logic re_q, re_d;
  logic rd_req_q, rd_req_d;
  logic inc_q, inc_d;
  logic err_q, err_d;
  logic oe_q, oe_d;
  logic [3:0] io_q, io_d;
  logic first;
  assign {cs_s, sck_s, io_s} = sync_q[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_d_q;
  assign fall    = ~sck_s & sck_d_q;
  assign cs_fall = ~cs_s & cs_d_q;
  assign first   = cnt_q == 5'd0;
  assign o_qspi_io = io_q;
  assign o_qspi_oe = oe_q;
  assign o_addr    = addr_q;
  assign o_wdata   = wdata_q;
  assign o_we      = we_q;
  assign o_re      = re_q;
  assign o_err     = err_q;
  assign o_busy    = ~cs_s & (state_q != S_IDLE);
  // Synchronise cs, sck and io through one shared chain so they stay aligned; reset to "cs low" so a held-low cs cannot start a frame
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      sck_d_q <= 1'b0;
      cs_d_q  <= 1'b0;
    end else begin
      sync_q[0] <= {I_qspi_cs, I_qspi_sck, i_qspi_io};
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      sck_d_q <= sck_s;
      cs_d_q  <= cs_s;
    end
  end
  // Frame decoder: next-state for the FSM, shifters, bus strobes and pad drive
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    wr_d      = wr_q;
    ash_d     = ash_q;
    addr_d    = inc_q ? addr_q + ADDR_WIDTH'(1) : addr_q;
    sh_d      = sh_q;
    wdata_d   = wdata_q;
    stage_d   = re_pipe_q[RD_LATENCY-1] ? i_rdata : stage_q;
    re_pipe_d = RD_LATENCY'({re_pipe_q, re_q});
    we_d      = 1'b0;
    re_d      = rd_req_q;
    rd_req_d  = 1'b0;
    inc_d     = 1'b0;
    err_d     = 1'b0;
    oe_d      = oe_q;
    io_d      = io_q;
    if (state_q != S_IDLE && cs_s) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      oe_d    = 1'b0;
      io_d    = 4'd0;
      re_d    = 1'b0;
      err_d   = state_q == S_CMD || state_q == S_ADDR;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_CMD;
            cnt_d   = 5'd0;
            op_d    = 8'd0;
            ash_d   = '0;
            sh_d    = '0;
          end
        end
        S_CMD: begin
          if (rise) begin
            op_d  = {op_q[6:0], io_s[0]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == C_LAST) begin
              cnt_d   = 5'd0;
              wr_d    = op_d == 8'h32;
              state_d = (op_d == 8'h32 || op_d == 8'h6B) ? S_ADDR : S_IGNORE;
              err_d   = op_d != 8'h32 && op_d != 8'h6B;
            end
          end
        end
        S_ADDR: begin
          if (rise) begin
            ash_d = {ash_q[ADDR_WIDTH-5:0], io_s};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == A_LAST) begin
              cnt_d    = 5'd0;
              addr_d   = ash_d;
              state_d  = wr_q ? S_WDATA : S_DUMMY;
              rd_req_d = ~wr_q;
            end
          end
        end
        S_DUMMY: begin
          if (rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == DM_LAST) begin
              cnt_d   = 5'd0;
              state_d = S_RDATA;
            end
          end
        end
        S_WDATA: begin
          if (rise) begin
            sh_d  = {sh_q[DATA_WIDTH-5:0], io_s};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == D_LAST) begin
              cnt_d   = 5'd0;
              wdata_d = sh_d;
              we_d    = 1'b1;
              inc_d   = 1'b1;
            end
          end
        end
        S_RDATA: begin
          if (fall) begin
            oe_d     = 1'b1;
            io_d     = first ? stage_q[DATA_WIDTH-1 -: 4] : sh_q[DATA_WIDTH-1 -: 4];
            sh_d     = (first ? stage_q : sh_q) << 4;
            cnt_d    = cnt_q == D_LAST ? 5'd0 : cnt_q + 5'd1;
            addr_d   = first ? addr_q + ADDR_WIDTH'(1) : addr_q;
            rd_req_d = first;
          end
        end
        default: ;
      endcase
    end
  end
  // State and datapath registers
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      wr_q      <= 1'b0;
      ash_q     <= '0;
      addr_q    <= '0;
      sh_q      <= '0;
      wdata_q   <= '0;
      stage_q   <= '0;
      re_pipe_q <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      rd_req_q  <= 1'b0;
      inc_q     <= 1'b0;
      err_q     <= 1'b0;
      oe_q      <= 1'b0;
      io_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      wr_q      <= wr_d;
      ash_q     <= ash_d;
      addr_q    <= addr_d;
      sh_q      <= sh_d;
      wdata_q   <= wdata_d;
      stage_q   <= stage_d;
      re_pipe_q <= re_pipe_d;
      we_q      <= we_d;
      re_q      <= re_d;
      rd_req_q  <= rd_req_d;
      inc_q     <= inc_d;
      err_q     <= err_d;
      oe_q      <= oe_d;
      io_q      <= io_d;
    end
  end
endmodule

// File: tb/tb_qspi_slave_sync.sv
// tb_qspi_slave_sync: scoreboard bench driving three differently sized slaves from one QSPI master
module tb_qspi_slave_sync;
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;
  localparam logic [1:0] K_WE = 2'd0;
  localparam logic [1:0] K_RE = 2'd1;
  localparam logic [1:0] K_ER = 2'd2;
  logic clk = 1'b0, rst = 1'b1, sck = 1'b0;
  logic [2:0] cs = 3'b111;
  logic [3:0] io = 4'd0;
  logic [3:0] qio0, qio1, qio2;
  logic oe0, oe1, oe2, we0, we1, we2, re0, re1, re2, busy0, busy1, busy2, err0, err1, err2;
  logic [23:0] addr0;
  logic [7:0] addr1, addr2;
  logic [7:0] wdata0, wdata1, rdata0;
  logic [15:0] wdata2;
  logic [23:0] rd_addr = '0;
  ev_t q0[$], q1[$], q2[$];
  logic [3:0] nib_q[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  qspi_slave_sync u0 (.I_clk(clk), .I_rst(rst), .I_qspi_sck(sck), .I_qspi_cs(cs[0]), .i_qspi_io(io),
    .o_qspi_io(qio0), .o_qspi_oe(oe0), .o_addr(addr0), .o_wdata(wdata0), .o_we(we0), .o_re(re0),
    .i_rdata(rdata0), .o_busy(busy0), .o_err(err0));
  qspi_slave_sync #(.ADDR_WIDTH(8)) u1 (.I_clk(clk), .I_rst(rst), .I_qspi_sck(sck), .I_qspi_cs(cs[1]),
    .i_qspi_io(io), .o_qspi_io(qio1), .o_qspi_oe(oe1), .o_addr(addr1), .o_wdata(wdata1), .o_we(we1),
    .o_re(re1), .i_rdata(8'h00), .o_busy(busy1), .o_err(err1));
  qspi_slave_sync #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) u2 (.I_clk(clk), .I_rst(rst), .I_qspi_sck(sck),
    .I_qspi_cs(cs[2]), .i_qspi_io(io), .o_qspi_io(qio2), .o_qspi_oe(oe2), .o_addr(addr2), .o_wdata(wdata2),
    .o_we(we2), .o_re(re2), .i_rdata(16'h0000), .o_busy(busy2), .o_err(err2));
  function automatic logic [7:0] mem(input logic [23:0] a);
    return a == 24'hFE ? 8'h11 : a == 24'hFF ? 8'h22 : 8'hEE;
  endfunction
  always @(posedge clk) if (re0) rd_addr <= addr0;
  assign rdata0 = mem(rd_addr);
  task automatic chk(input int i, input ev_t a);
    ev_t e;
    bit got;
    got = 1'b0;
    e = '0;
    if (i == 0 && q0.size() != 0) begin e = q0.pop_front(); got = 1'b1; end
    if (i == 1 && q1.size() != 0) begin e = q1.pop_front(); got = 1'b1; end
    if (i == 2 && q2.size() != 0) begin e = q2.pop_front(); got = 1'b1; end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL bus_event u%0d: got kind=%0d addr=%h data=%h, expected no event", i, a.kind, a.addr, a.data);
    end else if (e !== a) begin
      n_fail++;
      $display("FAIL bus_event u%0d: got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h",
               i, a.kind, a.addr, a.data, e.kind, e.addr, e.data);
    end
  endtask
  always @(negedge clk) begin
    if (we0) chk(0, '{K_WE, 32'(addr0), 32'(wdata0)});
    if (re0) chk(0, '{K_RE, 32'(addr0), 32'd0});
    if (err0) chk(0, '{K_ER, 32'd0, 32'd0});
    if (we1) chk(1, '{K_WE, 32'(addr1), 32'(wdata1)});
    if (re1) chk(1, '{K_RE, 32'(addr1), 32'd0});
    if (err1) chk(1, '{K_ER, 32'd0, 32'd0});
    if (we2) chk(2, '{K_WE, 32'(addr2), 32'(wdata2)});
    if (re2) chk(2, '{K_RE, 32'(addr2), 32'd0});
    if (err2) chk(2, '{K_ER, 32'd0, 32'd0});
  end
  always @(posedge sck) begin
    if (oe0 || oe1 || oe2) begin
      n_chk++;
      if (oe1 || oe2 || nib_q.size() == 0) begin
        n_fail++;
        $display("FAIL pin_nibble: got oe=%b%b%b io=%h, expected oe low", oe0, oe1, oe2, qio0);
      end else begin
        logic [3:0] e;
        e = nib_q.pop_front();
        if (qio0 !== e) begin
          n_fail++;
          $display("FAIL pin_nibble: got %h, expected %h", qio0, e);
        end
      end
    end
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic nib(input logic [3:0] n);
    io = n;
    #50 sck = 1'b1;
    #50 sck = 1'b0;
  endtask
  task automatic cmd(input logic [7:0] op);
    for (int k = 7; k >= 0; k--) nib({3'b000, op[k]});
  endtask
  task automatic nibs(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) nib(v[4*k +: 4]);
  endtask
  task automatic start(input int i);
    cs[i] = 1'b0;
    #50;
  endtask
  task automatic stop(input int i);
    #50 cs[i] = 1'b1;
    #150;
  endtask
  task automatic ev(input int i, input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
    if (i == 0) q0.push_back('{k, a, d});
    if (i == 1) q1.push_back('{k, a, d});
    if (i == 2) q2.push_back('{k, a, d});
  endtask
  initial begin
    cs = 3'b110;
    for (int k = 0; k < 4; k++) nib(4'hA);
    @(negedge clk) rst = 1'b0;
    #1;
    check("reset_u0", {qio0, oe0, addr0, wdata0, we0, re0, busy0, err0}, 64'd0);
    check("reset_u1", {qio1, oe1, addr1, wdata1, we1, re1, busy1, err1}, 64'd0);
    check("reset_u2", {qio2, oe2, addr2, wdata2, we2, re2, busy2, err2}, 64'd0);
    cmd(8'h32);
    nibs(32'h000100, 6);
    nibs(32'hA53C, 4);
    check("no_frame_busy", {63'd0, busy0}, 64'd0);
    stop(0);
    ev(0, K_WE, 32'h100, 32'hA5);
    ev(0, K_WE, 32'h101, 32'h3C);
    start(0);
    cmd(8'h32);
    check("busy_in_frame", {63'd0, busy0}, 64'd1);
    nibs(32'h000100, 6);
    nibs(32'hA53C, 4);
    stop(0);
    check("busy_after", {63'd0, busy0}, 64'd0);
    ev(0, K_RE, 32'hFE, 0);
    ev(0, K_RE, 32'hFF, 0);
    ev(0, K_RE, 32'h100, 0);
    nib_q.push_back(4'h1);
    nib_q.push_back(4'h1);
    nib_q.push_back(4'h2);
    nib_q.push_back(4'h2);
    start(0);
    cmd(8'h6B);
    nibs(32'h0000FE, 6);
    nibs(32'h0, 4);
    check("oe_before_data", {63'd0, oe0}, 64'd0);
    nibs(32'h0, 3);
    io = 4'd0;
    #50 sck = 1'b1;
    #50 cs[0] = 1'b1;
    #20 sck = 1'b0;
    #150;
    check("oe_after_read", {63'd0, oe0}, 64'd0);
    ev(1, K_WE, 32'hFF, 32'h12);
    ev(1, K_WE, 32'h00, 32'h34);
    start(1);
    cmd(8'h32);
    nibs(32'hFF, 2);
    nibs(32'h1234, 4);
    stop(1);
    ev(2, K_WE, 32'h10, 32'h1234);
    start(2);
    cmd(8'h32);
    nibs(32'h10, 2);
    nibs(32'h123456, 6);
    stop(2);
    ev(0, K_ER, 0, 0);
    start(0);
    cmd(8'h9F);
    nibs(32'h123456, 6);
    nibs(32'hABCD, 4);
    stop(0);
    ev(0, K_ER, 0, 0);
    start(0);
    cmd(8'h32);
    nibs(32'h000, 3);
    stop(0);
    check("busy_after_trunc", {63'd0, busy0}, 64'd0);
    ev(0, K_WE, 32'h200, 32'h7E);
    start(0);
    cmd(8'h32);
    nibs(32'h000200, 6);
    nibs(32'h7E, 2);
    stop(0);
    start(0);
    cmd(8'h32);
    nibs(32'h000300, 6);
    nib(4'h9);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midframe_reset_u0", {qio0, oe0, addr0, wdata0, we0, re0, busy0, err0}, 64'd0);
    nibs(32'h9876, 4);
    stop(0);
    #200;
    check("scoreboard_u0_left", 64'(q0.size()), 64'd0);
    check("scoreboard_u1_left", 64'(q1.size()), 64'd0);
    check("scoreboard_u2_left", 64'(q2.size()), 64'd0);
    check("nibbles_left", 64'(nib_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
